// File: rtl/cache_dm_wt.sv
// Direct-mapped, write-through, no-write-allocate cache between a CPU port and memory.
// Define CACHE_STATS_EN to add the saturating hit_cnt/miss_cnt outputs.
// state   | meaning
// S_IDLE  | serve hits, start fills/writes, accept flush
// S_FILL  | read WPL beats of a line from memory
// S_WRITE | write one word through to memory
module cache_dm_wt #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LINES  = 64,
    parameter int WPL    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              re,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wrt_data,
    input  logic              flush,
    output logic              hit,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdy
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
`endif
);

    localparam int OFF_W = $clog2(WPL);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WPL - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE} state_t;

    state_t              state_q, state_d;
    logic [OFF_W-1:0]    beat_q;
    logic [LINES-1:0]    valid_q;
    logic [ADDR_W-1:0]   lat_addr_q;
    logic [DATA_W-1:0]   lat_wdata_q;
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [DATA_W-1:0]   data_q [LINES*WPL];

    logic [OFF_W-1:0]    cpu_off, lat_off;
    logic [IDX_W-1:0]    cpu_idx, lat_idx;
    logic [TAG_W-1:0]    cpu_tag, lat_tag;
    logic                cpu_line_hit, lat_line_hit;
    logic                read_hit, start_fill, start_write, do_flush;
    logic                fill_wr, fill_last, wr_done;

    assign cpu_off = addr[OFF_W-1:0];
    assign cpu_idx = addr[OFF_W +: IDX_W];
    assign cpu_tag = addr[ADDR_W-1 -: TAG_W];
    assign lat_off = lat_addr_q[OFF_W-1:0];
    assign lat_idx = lat_addr_q[OFF_W +: IDX_W];
    assign lat_tag = lat_addr_q[ADDR_W-1 -: TAG_W];

    assign cpu_line_hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
    assign lat_line_hit = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);
    assign rd_data      = data_q[{cpu_idx, cpu_off}];

    always_comb begin
        state_d     = state_q;
        hit         = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        read_hit    = 1'b0;
        start_fill  = 1'b0;
        start_write = 1'b0;
        do_flush    = 1'b0;
        fill_wr     = 1'b0;
        fill_last   = 1'b0;
        wr_done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (we) begin
                    start_write = 1'b1;
                    state_d     = S_WRITE;
                end else if (re) begin
                    if (cpu_line_hit) begin
                        hit      = 1'b1;
                        read_hit = 1'b1;
                    end else begin
                        start_fill = 1'b1;
                        state_d    = S_FILL;
                    end
                end else if (flush) begin
                    do_flush = 1'b1;
                end
            end
            S_FILL: begin
                mem_re   = 1'b1;
                mem_addr = {lat_tag, lat_idx, beat_q};
                if (mem_rdy) begin
                    fill_wr = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        fill_last = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = lat_addr_q;
                mem_wdata = lat_wdata_q;
                if (mem_rdy) begin
                    hit     = 1'b1;
                    wr_done = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request is latched so a fill or write completes even if the CPU drops it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            valid_q     <= '0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_fill || start_write) begin
                lat_addr_q  <= addr;
                lat_wdata_q <= wrt_data;
            end
            if (start_fill) begin
                valid_q[cpu_idx] <= 1'b0;
                beat_q           <= '0;
            end
            if (fill_wr) begin
                beat_q <= beat_q + 1'b1;
            end
            if (fill_last) begin
                valid_q[lat_idx] <= 1'b1;
            end
            if (do_flush) begin
                valid_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_wr) begin
            data_q[{lat_idx, beat_q}] <= mem_rdata;
        end
        if (fill_last) begin
            tag_q[lat_idx] <= lat_tag;
        end
        if (wr_done && lat_line_hit) begin
            data_q[{lat_idx, lat_off}] <= lat_wdata_q;
        end
    end

`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (do_flush) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (read_hit && (hit_cnt_q != 16'hFFFF)) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if (start_fill && (miss_cnt_q != 16'hFFFF)) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_dm_wt.sv
// Self-checking bench for cache_dm_wt (default parameters) against a line-level reference model.
module tb_cache_dm_wt;

    localparam int WPL = 4;

    logic        clk = 1'b0;
    logic        rst, re, we, flush, mem_rdy;
    logic [15:0] addr, wrt_data, mem_rdata;
    logic        hit, mem_re, mem_we;
    logic [15:0] rd_data, mem_addr, mem_wdata;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    cache_dm_wt dut (
        .clk       (clk),
        .rst       (rst),
        .re        (re),
        .we        (we),
        .addr      (addr),
        .wrt_data  (wrt_data),
        .flush     (flush),
        .hit       (hit),
        .rd_data   (rd_data),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rdy   (mem_rdy)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [15:0] mem     [65536];
    logic [15:0] ref_mem [65536];
    bit          ref_valid [64];
    logic [7:0]  ref_tag   [64];
    int          exp_hits = 0;
    int          exp_misses = 0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hit(input logic [15:0] a);
        return ref_valid[a[7:2]] && (ref_tag[a[7:2]] == a[15:8]);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) ref_valid[i] = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic chk_stats(input string tag);
`ifdef CACHE_STATS_EN
        chk({tag, "_hit_cnt"}, hit_cnt, exp_hits);
        chk({tag, "_miss_cnt"}, miss_cnt, exp_misses);
`else
        if (tag.len() == 0) $display("stats disabled");
`endif
    endtask

    // delay >= 0: mem_rdy rises after 'delay' waiting cycles; delay < 0: random with pct% ready.
    task automatic access(input bit wr, input logic [15:0] a, input logic [15:0] d,
                          input int delay, input int pct, input bit drop, input bit fl);
        bit          line_hit, done, wpend;
        int          beats, cyc;
        logic [15:0] wa, wd;
        line_hit = model_hit(a);
        beats = 0; cyc = 0; done = 0;
        @(negedge clk);
        re = !wr; we = wr; addr = a; wrt_data = d; flush = fl; mem_rdy = 1'b0;
        #1;
        chk("idle_mem_re", mem_re, 0);
        chk("idle_mem_we", mem_we, 0);
        if (!wr && line_hit) begin
            chk("hit0", hit, 1);
            chk("hit0_data", rd_data, ref_mem[a]);
            exp_hits++;
            done = 1;
        end else begin
            chk("miss0", hit, 0);
            if (!wr) exp_misses++;
        end
        @(posedge clk);
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (drop) begin re = 0; we = 0; flush = 0; end
            mem_rdy   = (delay >= 0) ? (cyc > delay) : ($urandom_range(0, 99) < pct);
            mem_rdata = mem[mem_addr];
            #1;
            wpend = 0;
            if (wr) begin
                chk("wr_mem_we", mem_we, 1);
                chk("wr_mem_re", mem_re, 0);
                chk("wr_addr", mem_addr, a);
                chk("wr_wdata", mem_wdata, d);
                chk("wr_hit", hit, mem_rdy);
                if (mem_rdy) begin
                    wpend = 1; wa = mem_addr; wd = mem_wdata; done = 1;
                    if (delay >= 0) chk("wr_latency", cyc, delay + 1);
                end
            end else if (beats < WPL) begin
                chk("fill_re", mem_re, 1);
                chk("fill_we", mem_we, 0);
                chk("fill_addr", mem_addr, {a[15:2], 2'(beats)});
                chk("fill_hit", hit, 0);
                if (mem_rdy) begin
                    beats++;
                    if (beats == WPL) begin
                        ref_valid[a[7:2]] = 1'b1;
                        ref_tag[a[7:2]]   = a[15:8];
                        if (drop) done = 1;
                    end
                end
            end else begin
                chk("refill_hit", hit, 1);
                chk("refill_data", rd_data, ref_mem[a]);
                chk("refill_re", mem_re, 0);
                if (delay == 0) chk("refill_latency", cyc, WPL + 1);
                exp_hits++;
                done = 1;
            end
            @(posedge clk);
            if (wpend) mem[wa] = wd;
        end
        if (!done) chk("timeout", 0, 1);
        if (wr) ref_mem[a] = d;
    endtask

    task automatic idle(input int n, input bit fl);
        @(negedge clk);
        re = 0; we = 0; flush = fl; mem_rdy = 0;
        #1;
        chk("idle_no_hit", hit, 0);
        chk("idle_no_re", mem_re, 0);
        @(posedge clk);
        if (fl) model_clear();
        @(negedge clk);
        flush = 0;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        logic [7:0]  tags [4];
        logic [5:0]  idxs [4];
        logic [15:0] ra;
        int          r, dly;
        tags = '{8'h12, 8'h56, 8'h9A, 8'hEF};
        idxs = '{6'h0D, 6'h10, 6'h20, 6'h3F};
        rst = 0; re = 0; we = 0; flush = 0; mem_rdy = 0;
        addr = 0; wrt_data = 0; mem_rdata = 0;
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i < 4; i++) begin
            mem[16'h1234 + i]     = 16'(16'hA0 + i);
            ref_mem[16'h1234 + i] = 16'(16'hA0 + i);
        end
        model_clear();
        #12;
        chk("rst_mem_re", mem_re, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_hit", hit, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        @(negedge clk);
        rst = 1;
        chk_stats("after_reset");

        // cold miss, same-line hit, conflict refill
        access(0, 16'h1234, 0, 0, 100, 0, 0);
        access(0, 16'h1236, 0, 0, 100, 0, 0);
        chk("t2_data", rd_data, 16'hA2);
        access(0, 16'h5634, 0, 0, 100, 0, 0);
        access(0, 16'h1234, 0, 0, 100, 0, 0);
        access(0, 16'h5634, 0, 0, 100, 0, 0);
        chk_stats("after_fills");

        // write hit with delayed ready, then write miss without allocate
        access(1, 16'h5635, 16'hBEEF, 2, 100, 0, 0);
        access(0, 16'h5635, 0, 0, 100, 0, 0);
        chk("t4_beef", rd_data, 16'hBEEF);
        access(1, 16'h9900, 16'h1357, 0, 100, 0, 0);
        access(0, 16'h9900, 0, 0, 100, 0, 0);

        // flush together with a request is ignored; flush alone invalidates
        access(0, 16'h5636, 0, 0, 100, 0, 1);
        access(0, 16'h5634, 0, 0, 100, 0, 1);
        idle(1, 1);
        chk_stats("after_flush");
        access(0, 16'h5634, 0, 0, 100, 0, 0);

        // reset during beat 2 of a fill
        access(0, 16'h2340, 0, 0, 100, 0, 0);
        @(negedge clk);
        re = 1; we = 0; addr = 16'h7740; mem_rdy = 0;
        #1;
        chk("rf_miss", hit, 0);
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_rdy = 1;
            mem_rdata = mem[mem_addr];
            #1;
            chk("rf_mem_re", mem_re, 1);
            chk("rf_addr", mem_addr, 16'(16'h7740 + k));
            if (k < 2) @(posedge clk);
        end
        rst = 0;
        #1;
        chk("rf_re_drop", mem_re, 0);
        chk("rf_hit", hit, 0);
        chk("rf_addr0", mem_addr, 0);
        model_clear();
        re = 0; mem_rdy = 0;
        @(negedge clk);
        rst = 1;
        chk_stats("after_rst_fill");
        access(0, 16'h7740, 0, 0, 100, 0, 0);
        access(0, 16'h2340, 0, 0, 100, 0, 0);

        // request dropped mid-fill still completes the line
        access(0, 16'h9A80, 0, 0, 100, 1, 0);
        access(0, 16'h9A83, 0, 0, 100, 0, 0);

        for (int n = 0; n < 200; n++) begin
            r  = $urandom_range(0, 99);
            ra = {tags[$urandom_range(0, 3)], idxs[$urandom_range(0, 3)], 2'($urandom_range(0, 3))};
            dly = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, 3);
            if (r < 5) begin
                idle(0, 1);
                chk_stats("rand_flush");
            end else begin
                access(r < 35, ra, 16'($urandom), dly, 50,
                       $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);
            end
        end
        chk_stats("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
